// File: rtl/tlb_isr_req_splitter_if.sv
// Request/chunk handshake bundle used on both sides of the ISR TLB splitter.
// The same shape serves input requests (slave) and output chunks (master).
interface tlb_isr_req_splitter_if #(
    parameter int PADDR_BITS = 48,
    parameter int LEN_BITS   = 28,
    parameter int DEST_BITS  = 4
) ();
    logic                  valid;
    logic                  ready;
    logic [PADDR_BITS-1:0] paddr_host;
    logic [PADDR_BITS-1:0] paddr_card;
    logic [LEN_BITS-1:0]   len;
    logic                  last;
    logic [DEST_BITS-1:0]  dest;
    logic                  done;

    modport master (
        output valid, paddr_host, paddr_card, len, last, dest,
        input  ready, done
    );

    modport slave (
        input  valid, paddr_host, paddr_card, len, last, dest,
        output ready, done
    );
endinterface

// File: rtl/tlb_isr_req_splitter.sv
// Splits translated DMA requests into page- and size-bounded chunks and folds chunk completions
// back into one per-request completion. Optional stat counters: TLB_SPLIT_STATS_EN.
module tlb_isr_req_splitter #(
    parameter int PADDR_BITS     = 48,
    parameter int LEN_BITS       = 28,
    parameter int DEST_BITS      = 4,
    parameter int PG_BITS        = 21,
    parameter int MAX_CHUNK_BITS = 12,
    parameter int N_OUTSTANDING  = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    tlb_isr_req_splitter_if.slave  s,
    tlb_isr_req_splitter_if.master m,
    output logic        err_done_underflow,
    output logic [31:0] stat_reqs,
    output logic [31:0] stat_chunks
);

    localparam int LW = LEN_BITS + 1;
    localparam int PW = $clog2(N_OUTSTANDING);
    localparam logic [LW-1:0] PG_SIZE    = LW'(1) << PG_BITS;
    localparam logic [LW-1:0] CHUNK_MAX  = LW'(1) << MAX_CHUNK_BITS;
    localparam logic [PW:0]   FIFO_DEPTH = (PW+1)'(N_OUTSTANDING);

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [PADDR_BITS-1:0] host_q, card_q;
    logic [LEN_BITS-1:0]   rem_q;
    logic                  last_q;
    logic [DEST_BITS-1:0]  dest_q;

    logic [N_OUTSTANDING-1:0] fifo_q;
    logic [PW-1:0]            wr_q, rd_q;
    logic [PW:0]              cnt_q;
    logic                     s_done_q;

    logic [LW-1:0] host_room, card_room, chunk;
    logic          final_chunk, chunk_last;
    logic          full, accept, issue, pop;

    function automatic logic [LW-1:0] min2(input logic [LW-1:0] a, input logic [LW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    assign host_room   = PG_SIZE - LW'(host_q[PG_BITS-1:0]);
    assign card_room   = PG_SIZE - LW'(card_q[PG_BITS-1:0]);
    assign chunk       = min2(min2({1'b0, rem_q}, CHUNK_MAX), min2(host_room, card_room));
    assign final_chunk = (chunk == {1'b0, rem_q});
    assign chunk_last  = last_q & final_chunk;

    assign full = (cnt_q == FIFO_DEPTH);
    assign pop  = m.done && (cnt_q != '0);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        s.ready = 1'b0;
        m.valid = 1'b0;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                s.ready = 1'b1;
                if (s.valid) begin
                    accept = 1'b1;
                    if (s.len != '0) state_d = SPLIT;
                end
            end
            SPLIT: begin
                // FIFO-full is the only stall; downstream ready alone never gates m_valid
                m.valid = !full;
                if (!full && m.ready) begin
                    issue = 1'b1;
                    if (final_chunk) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m.paddr_host = host_q;
    assign m.paddr_card = card_q;
    assign m.len        = chunk[LEN_BITS-1:0];
    assign m.last       = chunk_last;
    assign m.dest       = dest_q;
    assign s.done       = s_done_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            host_q <= '0;
            card_q <= '0;
            rem_q  <= '0;
            last_q <= 1'b0;
            dest_q <= '0;
        end else if (accept) begin
            host_q <= s.paddr_host;
            card_q <= s.paddr_card;
            rem_q  <= s.len;
            last_q <= s.last;
            dest_q <= s.dest;
        end else if (issue) begin
            host_q <= host_q + PADDR_BITS'(chunk);
            card_q <= card_q + PADDR_BITS'(chunk);
            rem_q  <= rem_q - chunk[LEN_BITS-1:0];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fifo_q             <= '0;
            wr_q               <= '0;
            rd_q               <= '0;
            cnt_q              <= '0;
            s_done_q           <= 1'b0;
            err_done_underflow <= 1'b0;
        end else begin
            if (issue) begin
                fifo_q[wr_q] <= chunk_last;
                wr_q         <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            s_done_q <= pop & fifo_q[rd_q];
            case ({issue, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (m.done && (cnt_q == '0)) err_done_underflow <= 1'b1;
        end
    end

`ifdef TLB_SPLIT_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_reqs   <= '0;
            stat_chunks <= '0;
        end else begin
            if (accept) stat_reqs   <= stat_reqs + 32'd1;
            if (issue)  stat_chunks <= stat_chunks + 32'd1;
        end
    end
`else
    assign stat_reqs   = '0;
    assign stat_chunks = '0;
`endif

endmodule

// File: doc/tlb_isr_req_splitter.md
Name: tlb_isr_req_splitter

Overview:
- Sits directly upstream of the ISR TLB assign stage.
- Takes one translated DMA request carrying host and card physical addresses, length, last flag and dest, and cuts it into chunks.
- A chunk never crosses a host page, never crosses a card page, and never exceeds the maximum transfer size.
- Tracks per-chunk completions from downstream and returns a single completion per finished last-flagged request.

Parameters:
- PADDR_BITS, 48, physical address width (host and card).
- LEN_BITS, 28, request length width in bytes.
- DEST_BITS, 4, destination stream id width.
- PG_BITS, 21, log2 page size; 2 MB pages.
- MAX_CHUNK_BITS, 12, log2 max chunk bytes (4096).
- N_OUTSTANDING, 16, max issued-but-not-done chunks; power of 2.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  async active-low reset.
- s_valid  in  1  input request valid.
- s_ready  out  1  input request accepted when high with s_valid.
- s_paddr_host  in  PADDR_BITS  host physical address.
- s_paddr_card  in  PADDR_BITS  card physical address.
- s_len  in  LEN_BITS  bytes.
- s_last  in  1  request ends a transfer; completion required.
- s_dest  in  DEST_BITS  destination id.
- s_done  out  1  one-cycle pulse per completed last-flagged request.
- m_valid  out  1  chunk valid.
- m_ready  in  1  downstream accepts chunk.
- m_paddr_host  out  PADDR_BITS  chunk host address.
- m_paddr_card  out  PADDR_BITS  chunk card address.
- m_len  out  LEN_BITS  chunk bytes.
- m_last  out  1  final chunk of a last-flagged request.
- m_dest  out  DEST_BITS  copied from s_dest.
- m_done  in  1  one-cycle pulse per completed chunk; completions arrive in issue order.
- err_done_underflow  out  1  sticky: m_done seen with no outstanding chunk.
- stat_reqs  out  32  accepted requests (optional feature).
- stat_chunks  out  32  issued chunks (optional feature).

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; all address and length registers clear.
  - Completion FIFO empties; error and stat counters clear.
  - s_ready=1, m_valid=0, s_done=0.
  - A reset mid-transfer discards in-flight state; no completion is emitted for it.
- FSM IDLE:
  - s_ready=1.
  - On s_valid&s_ready, register all s_* fields.
  - If s_len != 0, go to SPLIT.
  - If s_len == 0, drop the request silently: stay IDLE, emit no chunk, no s_done.
- FSM SPLIT:
  - s_ready=0.
  - Chunk length, computed at LEN_BITS+1 width: chunk = min(rem_len, 2^PG_BITS - host[PG_BITS-1:0], 2^PG_BITS - card[PG_BITS-1:0], 2^MAX_CHUNK_BITS).
  - m_* outputs are driven from the current registers; m_len = chunk.
  - m_last = s_last_reg & (chunk == rem_len).
  - m_valid=1 unless the completion FIFO is full; that stall is the only source of backpressure.
  - Outputs hold stable while m_valid & !m_ready.
- Chunk handshake (m_valid&m_ready):
  - host += chunk; card += chunk; rem_len -= chunk.
  - Push m_last into the completion FIFO.
  - If chunk == rem_len, return to IDLE.
  - Back-to-back chunks issue every cycle.
- Latency:
  - Input accepted in cycle N; first chunk has m_valid in cycle N+1.
  - Next request can be accepted in the cycle after the final chunk handshake.
- Completion FIFO (depth N_OUTSTANDING, 1-bit entries):
  - m_done pops one entry.
  - If the popped entry is 1, s_done pulses in the next cycle (registered).
  - Push and pop in the same cycle: the count is unchanged.
  - Full: m_valid is held low until a pop.
  - m_done while empty: ignored and sets err_done_underflow (cleared only by reset).
- Address arithmetic is modulo 2^PADDR_BITS.
- Page crossing is evaluated independently for host and card; the smaller room wins.

Optional Feature:
- Macro: TLB_SPLIT_STATS_EN.
- Defined:
  - stat_reqs increments on each input handshake, including zero-length requests.
  - stat_chunks increments on each chunk handshake.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: counters are not built; both stat ports are tied to 0.

Test Plan:
- host=0x0, card=0x0, len=0x2800, last=1, m_ready=1 -> three chunks on consecutive cycles: len 0x1000, 0x1000, 0x800; hosts 0x0, 0x1000, 0x2000; m_last only on the third; after three m_done pulses, exactly one s_done pulse.
- host=0x1FFF00, card=0x0, len=0x200 -> chunks 0x100 @host 0x1FFF00, then 0x100 @host 0x200000 / card 0x100.
- host=0x0, card=0x3FFF80, len=0x100, last=0 -> chunks 0x80 and 0x80; m_last=0 on both; no s_done after both m_done pulses.
- m_ready=0 for 5 cycles mid-request -> m_* held constant with m_valid=1; 17 chunks with no m_done -> m_valid drops after the 16th; one m_done -> the 17th issues.
- len=0, last=1 -> s_ready stays 1, no m_valid, no s_done; a m_done with no outstanding chunk -> err_done_underflow=1.
- aresetn asserted mid-SPLIT with 3 outstanding chunks -> m_valid=0 and s_ready=1 immediately; subsequent m_done pulses set err_done_underflow and produce no s_done; with TLB_SPLIT_STATS_EN, stat counters read 0.
